// File: rtl/wisc_ctrl_pkg.sv
// Shared definitions for the WISC-F24 decode stage: opcodes, control-bundle
// layout and encodings, and the halt-drain state encoding.
package wisc_ctrl_pkg;

   localparam int OPC_W  = 5;
   localparam int CTRL_W = 25;

   // Opcodes (instr[INSTR_W-1 -: 5])
   localparam logic [4:0] OP_HALT  = 5'b00000;
   localparam logic [4:0] OP_NOP   = 5'b00001;
   localparam logic [4:0] OP_SIIC  = 5'b00010;
   localparam logic [4:0] OP_J     = 5'b00100;
   localparam logic [4:0] OP_JR    = 5'b00101;
   localparam logic [4:0] OP_JAL   = 5'b00110;
   localparam logic [4:0] OP_JALR  = 5'b00111;
   localparam logic [4:0] OP_ADDI  = 5'b01000;
   localparam logic [4:0] OP_SUBI  = 5'b01001;
   localparam logic [4:0] OP_XORI  = 5'b01010;
   localparam logic [4:0] OP_ANDNI = 5'b01011;
   localparam logic [4:0] OP_BEQZ  = 5'b01100;
   localparam logic [4:0] OP_BNEZ  = 5'b01101;
   localparam logic [4:0] OP_BLTZ  = 5'b01110;
   localparam logic [4:0] OP_BGEZ  = 5'b01111;
   localparam logic [4:0] OP_ST    = 5'b10000;
   localparam logic [4:0] OP_LD    = 5'b10001;
   localparam logic [4:0] OP_SLBI  = 5'b10010;
   localparam logic [4:0] OP_STU   = 5'b10011;
   localparam logic [4:0] OP_ROLI  = 5'b10100;
   localparam logic [4:0] OP_SLLI  = 5'b10101;
   localparam logic [4:0] OP_RORI  = 5'b10110;
   localparam logic [4:0] OP_SRLI  = 5'b10111;
   localparam logic [4:0] OP_LBI   = 5'b11000;
   localparam logic [4:0] OP_BTR   = 5'b11001;
   localparam logic [4:0] OP_SHFT  = 5'b11010;
   localparam logic [4:0] OP_ALU   = 5'b11011;
   localparam logic [4:0] OP_SEQ   = 5'b11100;
   localparam logic [4:0] OP_SLT   = 5'b11101;
   localparam logic [4:0] OP_SLE   = 5'b11110;
   localparam logic [4:0] OP_SCO   = 5'b11111;

   // Control-bundle bit offsets (LSB of each field) and widths
   localparam int CF_ERR    = 24;
   localparam int CF_HALT   = 23;
   localparam int CF_REGWRT = 22;
   localparam int CF_MEMWRT = 21;
   localparam int CF_MEMRD  = 20;
   localparam int CF_CIN    = 19;
   localparam int CF_INVA   = 18;
   localparam int CF_INVB   = 17;
   localparam int CF_SOPSEL = 16;
   localparam int CF_BRCH   = 13;
   localparam int CW_BRCH   = 3;
   localparam int CF_WBSEL  = 11;
   localparam int CW_WBSEL  = 2;
   localparam int CF_BSRC   = 9;
   localparam int CW_BSRC   = 2;
   localparam int CF_RDSEL  = 7;
   localparam int CW_RDSEL  = 2;
   localparam int CF_ZEXT   = 6;
   localparam int CF_JUMP   = 5;
   localparam int CF_BRANCH = 4;
   localparam int CF_REGJMP = 3;
   localparam int CF_ALUOP  = 0;
   localparam int CW_ALUOP  = 3;

   typedef enum logic [2:0] {
      BR_NONE = 3'b000, BR_CO = 3'b001, BR_EQ = 3'b010, BR_NE = 3'b011,
      BR_LT   = 3'b100, BR_GE = 3'b101, BR_LE = 3'b110
   } brch_e;

   typedef enum logic [1:0] {
      WB_MEM = 2'b00, WB_PC2 = 2'b01, WB_ALU = 2'b10, WB_IMM = 2'b11
   } wb_sel_e;

   typedef enum logic [1:0] {
      BS_REG = 2'b00, BS_IMM5 = 2'b01, BS_IMM8 = 2'b10, BS_ZERO = 2'b11
   } b_src_e;

   typedef enum logic [1:0] {
      RD_RTYPE = 2'b00, RD_ITYPE = 2'b01, RD_RS = 2'b10, RD_R7 = 2'b11
   } rd_sel_e;

   typedef enum logic [2:0] {
      ALU_ADD = 3'd0, ALU_XOR = 3'd1, ALU_AND = 3'd2, ALU_ROL = 3'd3,
      ALU_SLL = 3'd4, ALU_ROR = 3'd5, ALU_SRL = 3'd6, ALU_BTR = 3'd7
   } alu_op_e;

   typedef enum logic [1:0] {
      ST_RUN = 2'd0, ST_HALT_PEND = 2'd1, ST_HALTED = 2'd2
   } state_e;

   // Field order MSB..LSB matches the CF_* offsets above
   typedef struct packed {
      logic    err;
      logic    halt;
      logic    reg_wrt;
      logic    mem_wrt;
      logic    mem_rd;
      logic    cin;
      logic    inv_a;
      logic    inv_b;
      logic    s_op_sel;
      brch_e   brch_sig;
      wb_sel_e wb_data_sel;
      b_src_e  b_src;
      rd_sel_e reg_dest_sel;
      logic    zero_ext;
      logic    jump;
      logic    branch;
      logic    reg_jump;
      alu_op_e alu_op;
   } ctrl_t;

endpackage

// File: rtl/ctrl_decode.sv
// Purely combinational WISC-F24 instruction decoder: opcode/func in,
// packed control bundle out. Undefined opcodes raise only err.
module ctrl_decode
   import wisc_ctrl_pkg::*;
(
   input  logic [OPC_W-1:0]  opcode_i,
   input  logic [1:0]        func_i,
   output logic [CTRL_W-1:0] ctrl_o
);

   ctrl_t c;

   // Table decode; every field defaults to zero before the opcode case
   always_comb begin
      c = '0;
      case (opcode_i)
         OP_HALT: c.halt = 1'b1;
         OP_NOP, OP_SIIC: begin end
         OP_ADDI, OP_SUBI, OP_XORI, OP_ANDNI,
         OP_ROLI, OP_SLLI, OP_RORI, OP_SRLI: begin
            c.reg_wrt      = 1'b1;
            c.wb_data_sel  = WB_ALU;
            c.b_src        = BS_IMM5;
            c.reg_dest_sel = RD_ITYPE;
            case (opcode_i)
               OP_SUBI:  begin c.cin = 1'b1; c.inv_a = 1'b1; c.alu_op = ALU_ADD; end
               OP_XORI:  begin c.zero_ext = 1'b1; c.alu_op = ALU_XOR; end
               OP_ANDNI: begin c.zero_ext = 1'b1; c.inv_b = 1'b1; c.alu_op = ALU_AND; end
               OP_ROLI:  c.alu_op = ALU_ROL;
               OP_SLLI:  c.alu_op = ALU_SLL;
               OP_RORI:  c.alu_op = ALU_ROR;
               OP_SRLI:  c.alu_op = ALU_SRL;
               default:  c.alu_op = ALU_ADD;
            endcase
         end
         OP_ST: begin
            c.mem_wrt = 1'b1;
            c.b_src   = BS_IMM5;
         end
         OP_LD: begin
            c.reg_wrt      = 1'b1;
            c.mem_rd       = 1'b1;
            c.wb_data_sel  = WB_MEM;
            c.b_src        = BS_IMM5;
            c.reg_dest_sel = RD_ITYPE;
         end
         OP_STU: begin
            c.reg_wrt      = 1'b1;
            c.mem_wrt      = 1'b1;
            c.wb_data_sel  = WB_ALU;
            c.b_src        = BS_IMM5;
            c.reg_dest_sel = RD_RS;
         end
         OP_SLBI, OP_LBI: begin
            c.reg_wrt      = 1'b1;
            c.wb_data_sel  = WB_IMM;
            c.b_src        = BS_IMM8;
            c.reg_dest_sel = RD_RS;
            c.zero_ext     = (opcode_i == OP_SLBI);
         end
         OP_BTR: begin
            c.reg_wrt     = 1'b1;
            c.wb_data_sel = WB_ALU;
            c.alu_op      = ALU_BTR;
         end
         OP_ALU: begin
            c.reg_wrt     = 1'b1;
            c.wb_data_sel = WB_ALU;
            case (func_i)
               2'b00: c.alu_op = ALU_ADD;
               2'b01: begin c.cin = 1'b1; c.inv_a = 1'b1; c.alu_op = ALU_ADD; end
               2'b10: c.alu_op = ALU_XOR;
               default: begin c.inv_b = 1'b1; c.alu_op = ALU_AND; end
            endcase
         end
         OP_SHFT: begin
            c.reg_wrt     = 1'b1;
            c.wb_data_sel = WB_ALU;
            case (func_i)
               2'b00:   c.alu_op = ALU_ROL;
               2'b01:   c.alu_op = ALU_SLL;
               2'b10:   c.alu_op = ALU_ROR;
               default: c.alu_op = ALU_SRL;
            endcase
         end
         // Set-on-compare ops compute Rs-Rt except SCO, which needs Rs+Rt carry
         OP_SEQ, OP_SLT, OP_SLE, OP_SCO: begin
            c.reg_wrt     = 1'b1;
            c.wb_data_sel = WB_ALU;
            c.s_op_sel    = 1'b1;
            c.cin         = (opcode_i != OP_SCO);
            c.inv_b       = (opcode_i != OP_SCO);
            case (opcode_i)
               OP_SEQ:  c.brch_sig = BR_EQ;
               OP_SLT:  c.brch_sig = BR_LT;
               OP_SLE:  c.brch_sig = BR_LE;
               default: c.brch_sig = BR_CO;
            endcase
         end
         OP_BEQZ, OP_BNEZ, OP_BLTZ, OP_BGEZ: begin
            c.branch = 1'b1;
            c.b_src  = BS_IMM8;
            case (opcode_i)
               OP_BEQZ: c.brch_sig = BR_EQ;
               OP_BNEZ: c.brch_sig = BR_NE;
               OP_BLTZ: c.brch_sig = BR_LT;
               default: c.brch_sig = BR_GE;
            endcase
         end
         OP_J: c.jump = 1'b1;
         OP_JR: begin
            c.jump     = 1'b1;
            c.reg_jump = 1'b1;
            c.b_src    = BS_IMM8;
         end
         OP_JAL, OP_JALR: begin
            c.jump         = 1'b1;
            c.reg_wrt      = 1'b1;
            c.wb_data_sel  = WB_PC2;
            c.reg_dest_sel = RD_R7;
            if (opcode_i == OP_JALR) begin
               c.reg_jump = 1'b1;
               c.b_src    = BS_IMM8;
            end
         end
         default: c.err = 1'b1;
      endcase
   end

   assign ctrl_o = c;

endmodule

// File: rtl/ctrl_decode_stage.sv
// WISC-F24 decode stage: valid/ready input FIFO, decoded head presented to
// execute, branch flush, HALT drain state machine and sticky illegal flag.
// Optional issue counter enabled by defining CTRL_ISSUE_COUNT_EN.
module ctrl_decode_stage
   import wisc_ctrl_pkg::*;
#(
   parameter int INSTR_W = 16,
   parameter int PC_W    = 16,
   parameter int DEPTH   = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [INSTR_W-1:0] in_instr,
   input  logic [PC_W-1:0]    in_pc,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [INSTR_W-1:0] out_instr,
   output logic [PC_W-1:0]    out_pc,
   output logic [CTRL_W-1:0]  out_ctrl,
   input  logic               flush,
   output logic               halted,
   output logic               err_sticky,
   output logic [31:0]        count
);

   localparam int AW    = $clog2(DEPTH);
   localparam int PTR_W = AW + 1;

   logic [INSTR_W-1:0] instr_q [DEPTH];
   logic [PC_W-1:0]    pc_q    [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   state_e             state_q, state_d;
   logic               err_q, err_d;

   logic [AW-1:0]      wr_idx, rd_idx;
   logic               empty, full, push, pop, do_push;
   logic [OPC_W-1:0]   head_op, in_op;
   logic [CTRL_W-1:0]  head_ctrl;
   logic [DEPTH-1:0]   we;

   assign wr_idx  = wr_ptr_q[AW-1:0];
   assign rd_idx  = rd_ptr_q[AW-1:0];
   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_idx == rd_idx);
   assign push    = in_valid & in_ready;
   assign pop     = out_valid & out_ready;
   // Flush squashes a same-cycle push
   assign do_push = push & ~flush;

   assign out_instr = instr_q[rd_idx];
   assign out_pc    = pc_q[rd_idx];
   assign head_op   = out_instr[INSTR_W-1 -: OPC_W];
   assign in_op     = in_instr[INSTR_W-1 -: OPC_W];

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_we
      assign we[gi] = do_push && (wr_idx == AW'(gi));
   end

   ctrl_decode u_decode (
      .opcode_i (head_op),
      .func_i   (out_instr[1:0]),
      .ctrl_o   (head_ctrl)
   );

   assign out_ctrl = out_valid ? head_ctrl : '0;

   // Entry storage written at the tail slot
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            instr_q[i] <= '0;
            pc_q[i]    <= '0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (we[i]) begin
               instr_q[i] <= in_instr;
               pc_q[i]    <= in_pc;
            end
         end
      end
   end

   // Pointer and sticky-error next state; flush rewinds both pointers
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop)     rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      err_d = err_q | (out_valid & head_ctrl[CF_ERR]);
   end

   // Pointer, error and state registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         err_q    <= 1'b0;
         state_q  <= ST_RUN;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         err_q    <= err_d;
         state_q  <= state_d;
      end
   end

   // Halt drain: only one HALT can be queued, and it is always the youngest
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RUN:
            if (do_push && in_op == OP_HALT) state_d = ST_HALT_PEND;
         ST_HALT_PEND:
            if (flush)                          state_d = ST_RUN;
            else if (pop && head_op == OP_HALT) state_d = ST_HALTED;
         ST_HALTED:
            state_d = ST_HALTED;
         default:
            state_d = ST_RUN;
      endcase
   end

   // Handshake and status outputs derived from state
   always_comb begin
      in_ready  = ~full & (state_q == ST_RUN);
      out_valid = ~empty & (state_q != ST_HALTED);
      halted    = (state_q == ST_HALTED);
   end

   assign err_sticky = err_q;

`ifdef CTRL_ISSUE_COUNT_EN
   logic [31:0] count_q, count_d;

   // Count every retired non-NOP; wraps naturally at 2^32
   always_comb begin
      count_d = count_q;
      if (pop && head_op != OP_NOP) count_d = count_q + 32'd1;
   end

   // Issue counter register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) count_q <= '0;
      else     count_q <= count_d;
   end

   assign count = count_q;
`else
   assign count = 32'd0;
`endif

endmodule

// File: tb/tb_ctrl_decode_stage.sv
// Self-checking bench for ctrl_decode_stage: directed steps followed by a
// randomized phase, all checked against a queue-based reference model.
module tb_ctrl_decode_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] in_instr = '0;
   logic [15:0] in_pc = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] out_instr;
   logic [15:0] out_pc;
   logic [24:0] out_ctrl;
   logic        flush = 1'b0;
   logic        halted;
   logic        err_sticky;
   logic [31:0] count;

   int total = 0;
   int bad   = 0;

   // Reference model state
   logic [15:0] q_instr[$];
   logic [15:0] q_pc[$];
   bit          m_pend, m_halted, m_err;
   logic [31:0] m_count;

   ctrl_decode_stage #(.INSTR_W(16), .PC_W(16), .DEPTH(2)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
      .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
      .out_pc(out_pc), .out_ctrl(out_ctrl), .flush(flush),
      .halted(halted), .err_sticky(err_sticky), .count(count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Bundle assembled from named fields, MSB first
   function automatic logic [24:0] f(input bit err, halt, rw, mw, mr, cin, ia, ib, sop,
                                     input bit [2:0] br, input bit [1:0] wb, bs, rd,
                                     input bit ze, j, b, rj, input bit [2:0] alu);
      return {err, halt, rw, mw, mr, cin, ia, ib, sop, br, wb, bs, rd, ze, j, b, rj, alu};
   endfunction

   // ISA table: wb 0=mem 1=pc+2 2=alu 3=imm; bsrc 1=imm5 2=imm8; rd 0=Rd(R) 1=Rd(I) 2=Rs 3=R7
   // alu 0=add 1=xor 2=and 3=rol 4=sll 5=ror 6=srl 7=btr
   function automatic logic [24:0] ref_decode(input logic [15:0] ins);
      logic [4:0] op;
      logic [1:0] fn;
      op = ins[15:11];
      fn = ins[1:0];
      case (op)
         5'b00000: return f(0,1,0,0,0,0,0,0,0, 3'd0, 2'd0, 2'd0, 2'd0, 0,0,0,0, 3'd0); // HALT
         5'b00001, 5'b00010: return '0;                                                  // NOP, SIIC
         5'b01000: return f(0,0,1,0,0,0,0,0,0, 3'd0, 2'd2, 2'd1, 2'd1, 0,0,0,0, 3'd0); // ADDI
         5'b01001: return f(0,0,1,0,0,1,1,0,0, 3'd0, 2'd2, 2'd1, 2'd1, 0,0,0,0, 3'd0); // SUBI
         5'b01010: return f(0,0,1,0,0,0,0,0,0, 3'd0, 2'd2, 2'd1, 2'd1, 1,0,0,0, 3'd1); // XORI
         5'b01011: return f(0,0,1,0,0,0,0,1,0, 3'd0, 2'd2, 2'd1, 2'd1, 1,0,0,0, 3'd2); // ANDNI
         5'b10100, 5'b10101, 5'b10110, 5'b10111:                                        // shift-imm
            return f(0,0,1,0,0,0,0,0,0, 3'd0, 2'd2, 2'd1, 2'd1, 0,0,0,0, 3'(op[1:0]) + 3'd3);
         5'b10000: return f(0,0,0,1,0,0,0,0,0, 3'd0, 2'd0, 2'd1, 2'd0, 0,0,0,0, 3'd0); // ST
         5'b10001: return f(0,0,1,0,1,0,0,0,0, 3'd0, 2'd0, 2'd1, 2'd1, 0,0,0,0, 3'd0); // LD
         5'b10011: return f(0,0,1,1,0,0,0,0,0, 3'd0, 2'd2, 2'd1, 2'd2, 0,0,0,0, 3'd0); // STU
         5'b10010: return f(0,0,1,0,0,0,0,0,0, 3'd0, 2'd3, 2'd2, 2'd2, 1,0,0,0, 3'd0); // SLBI
         5'b11000: return f(0,0,1,0,0,0,0,0,0, 3'd0, 2'd3, 2'd2, 2'd2, 0,0,0,0, 3'd0); // LBI
         5'b11001: return f(0,0,1,0,0,0,0,0,0, 3'd0, 2'd2, 2'd0, 2'd0, 0,0,0,0, 3'd7); // BTR
         5'b11011: begin                                                                 // ADD/SUB/XOR/ANDN
            if (fn == 2'b00) return f(0,0,1,0,0,0,0,0,0, 3'd0, 2'd2, 2'd0, 2'd0, 0,0,0,0, 3'd0);
            if (fn == 2'b01) return f(0,0,1,0,0,1,1,0,0, 3'd0, 2'd2, 2'd0, 2'd0, 0,0,0,0, 3'd0);
            if (fn == 2'b10) return f(0,0,1,0,0,0,0,0,0, 3'd0, 2'd2, 2'd0, 2'd0, 0,0,0,0, 3'd1);
            return f(0,0,1,0,0,0,0,1,0, 3'd0, 2'd2, 2'd0, 2'd0, 0,0,0,0, 3'd2);
         end
         5'b11010: return f(0,0,1,0,0,0,0,0,0, 3'd0, 2'd2, 2'd0, 2'd0, 0,0,0,0, 3'(fn) + 3'd3);
         5'b11100: return f(0,0,1,0,0,1,0,1,1, 3'b010, 2'd2, 2'd0, 2'd0, 0,0,0,0, 3'd0); // SEQ
         5'b11101: return f(0,0,1,0,0,1,0,1,1, 3'b100, 2'd2, 2'd0, 2'd0, 0,0,0,0, 3'd0); // SLT
         5'b11110: return f(0,0,1,0,0,1,0,1,1, 3'b110, 2'd2, 2'd0, 2'd0, 0,0,0,0, 3'd0); // SLE
         5'b11111: return f(0,0,1,0,0,0,0,0,1, 3'b001, 2'd2, 2'd0, 2'd0, 0,0,0,0, 3'd0); // SCO
         5'b01100: return f(0,0,0,0,0,0,0,0,0, 3'b010, 2'd0, 2'd2, 2'd0, 0,0,1,0, 3'd0); // BEQZ
         5'b01101: return f(0,0,0,0,0,0,0,0,0, 3'b011, 2'd0, 2'd2, 2'd0, 0,0,1,0, 3'd0); // BNEZ
         5'b01110: return f(0,0,0,0,0,0,0,0,0, 3'b100, 2'd0, 2'd2, 2'd0, 0,0,1,0, 3'd0); // BLTZ
         5'b01111: return f(0,0,0,0,0,0,0,0,0, 3'b101, 2'd0, 2'd2, 2'd0, 0,0,1,0, 3'd0); // BGEZ
         5'b00100: return f(0,0,0,0,0,0,0,0,0, 3'd0, 2'd0, 2'd0, 2'd0, 0,1,0,0, 3'd0);   // J
         5'b00101: return f(0,0,0,0,0,0,0,0,0, 3'd0, 2'd0, 2'd2, 2'd0, 0,1,0,1, 3'd0);   // JR
         5'b00110: return f(0,0,1,0,0,0,0,0,0, 3'd0, 2'd1, 2'd0, 2'd3, 0,1,0,0, 3'd0);   // JAL
         5'b00111: return f(0,0,1,0,0,0,0,0,0, 3'd0, 2'd1, 2'd2, 2'd3, 0,1,0,1, 3'd0);   // JALR
         default:  return f(1,0,0,0,0,0,0,0,0, 3'd0, 2'd0, 2'd0, 2'd0, 0,0,0,0, 3'd0);   // undefined
      endcase
   endfunction

   function automatic bit exp_valid();
      return (q_instr.size() > 0) && !m_halted;
   endfunction

   function automatic bit exp_in_ready();
      return (q_instr.size() < 2) && !m_pend && !m_halted;
   endfunction

   function automatic logic [31:0] exp_count();
`ifdef CTRL_ISSUE_COUNT_EN
      return m_count;
`else
      return 32'd0;
`endif
   endfunction

   task automatic model_reset();
      q_instr.delete();
      q_pc.delete();
      m_pend   = 0;
      m_halted = 0;
      m_err    = 0;
      m_count  = '0;
   endtask

   task automatic check_all(input string ph);
      logic [24:0] ec;
      ec = exp_valid() ? ref_decode(q_instr[0]) : '0;
      chk({ph, ".out_valid"}, out_valid, exp_valid());
      chk({ph, ".in_ready"}, in_ready, exp_in_ready());
      chk({ph, ".out_ctrl"}, out_ctrl, ec);
      chk({ph, ".halted"}, halted, m_halted);
      chk({ph, ".err_sticky"}, err_sticky, m_err);
      chk({ph, ".count"}, count, exp_count());
      if (exp_valid()) begin
         chk({ph, ".out_instr"}, out_instr, q_instr[0]);
         chk({ph, ".out_pc"}, out_pc, q_pc[0]);
      end
   endtask

   // One clock: drive at negedge, check pre-edge outputs, then advance the model
   task automatic cyc(input string ph, input bit iv, input logic [15:0] ins,
                      input logic [15:0] pc, input bit ordy, input bit fl);
      bit          push, pop, v;
      logic [24:0] hc;
      logic [15:0] head;
      @(negedge clk);
      in_valid  = iv;
      in_instr  = ins;
      in_pc     = pc;
      out_ready = ordy;
      flush     = fl;
      #1;
      check_all(ph);
      v    = exp_valid();
      push = iv && exp_in_ready();
      pop  = v && ordy;
      head = v ? q_instr[0] : 16'h0;
      hc   = v ? ref_decode(head) : '0;
      @(posedge clk);
      if (v && hc[24]) m_err = 1;
      if (pop && head[15:11] != 5'b00001) m_count++;
      if (fl) begin
         q_instr.delete();
         q_pc.delete();
         m_pend = 0;
      end else begin
         if (pop) begin
            void'(q_instr.pop_front());
            void'(q_pc.pop_front());
            if (m_pend && head[15:11] == 5'b00000) begin
               m_pend   = 0;
               m_halted = 1;
            end
         end
         if (push) begin
            q_instr.push_back(ins);
            q_pc.push_back(pc);
            if (ins[15:11] == 5'b00000) m_pend = 1;
         end
      end
   endtask

   // Reset asserted mid-cycle; outputs must respond without a clock edge
   task automatic async_reset();
      @(negedge clk);
      in_valid  = 0;
      out_ready = 0;
      flush     = 0;
      #2 rst = 1;
      #1;
      chk("arst.out_valid", out_valid, 1'b0);
      chk("arst.in_ready", in_ready, 1'b1);
      chk("arst.halted", halted, 1'b0);
      chk("arst.err_sticky", err_sticky, 1'b0);
      chk("arst.count", count, 32'd0);
      chk("arst.out_ctrl", out_ctrl, 25'd0);
      chk("arst.out_instr", out_instr, 16'd0);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rst = 0;
   endtask

   initial begin
      int          halt_wait;
      logic [4:0]  op;
      logic [15:0] ri;
      model_reset();

      // Reset values
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst.out_valid", out_valid, 1'b0);
      chk("rst.in_ready", in_ready, 1'b1);
      chk("rst.halted", halted, 1'b0);
      chk("rst.err_sticky", err_sticky, 1'b0);
      chk("rst.count", count, 32'd0);
      chk("rst.out_instr", out_instr, 16'd0);
      chk("rst.out_pc", out_pc, 16'd0);
      chk("rst.out_ctrl", out_ctrl, 25'd0);
      rst = 0;

      // ADDI into empty stage: visible one cycle later
      cyc("addi", 1, 16'h4000, 16'h0100, 1, 0);
      #1;
      chk("addi.valid", out_valid, 1'b1);
      chk("addi.bundle", out_ctrl, 25'h0401280);
      chk("addi.in_ready", in_ready, 1'b1);
      cyc("addi_pop", 0, 16'h0, 16'h0, 1, 0);

      // Backpressure: third push waits until the head drains
      cyc("bp1", 1, 16'h4001, 16'h0200, 0, 0);
      cyc("bp2", 1, 16'h5002, 16'h0202, 0, 0);
      #1;
      chk("bp.full_in_ready", in_ready, 1'b0);
      cyc("bp3", 1, 16'hD803, 16'h0204, 0, 0);
      cyc("bp4", 1, 16'hD803, 16'h0204, 1, 0);
      cyc("bp5", 1, 16'hD803, 16'h0204, 1, 0);
      cyc("bp6", 0, 16'h0, 16'h0, 1, 0);
      cyc("bp7", 0, 16'h0, 16'h0, 1, 0);

      // Flush beats a same-cycle push
      cyc("fl1", 1, 16'hD801, 16'h0300, 0, 0);
      cyc("fl2", 1, 16'h4123, 16'h0302, 0, 1);
      #1;
      chk("fl.out_valid", out_valid, 1'b0);
      cyc("fl3", 0, 16'h0, 16'h0, 1, 0);

      // HALT behind ADD drains then halts
      cyc("h1", 1, 16'hD800, 16'h0400, 0, 0);
      cyc("h2", 1, 16'h0000, 16'h0402, 1, 0);
      #1;
      chk("h.in_ready_pend", in_ready, 1'b0);
      cyc("h3", 1, 16'h4000, 16'h0404, 1, 0);
      #1;
      chk("h.halted", halted, 1'b1);
      chk("h.out_valid", out_valid, 1'b0);
      cyc("h4", 1, 16'h4000, 16'h0406, 1, 0);
      cyc("h5", 1, 16'h4000, 16'h0408, 1, 0);
      async_reset();

      // Flush while HALT pending returns to run
      cyc("hf1", 1, 16'h0000, 16'h0500, 0, 0);
      #1;
      chk("hf.in_ready_pend", in_ready, 1'b0);
      cyc("hf2", 0, 16'h0, 16'h0, 0, 1);
      #1;
      chk("hf.in_ready", in_ready, 1'b1);
      chk("hf.halted", halted, 1'b0);

      // Undefined opcode latches err_sticky until reset
      cyc("e1", 1, 16'h1800, 16'h0600, 1, 0);
      cyc("e2", 0, 16'h0, 16'h0, 1, 0);
      #1;
      chk("e.sticky", err_sticky, 1'b1);
      cyc("e3", 1, 16'h4000, 16'h0602, 1, 1);
      cyc("e4", 0, 16'h0, 16'h0, 1, 0);
      async_reset();

      // Five non-NOP pops and one NOP pop
      for (int i = 0; i < 6; i++)
         cyc("cnt", 1, (i == 2) ? 16'h0800 : 16'h4000 + 16'(i), 16'(16'h0700 + 2 * i), 1, 0);
      cyc("cnt_d1", 0, 16'h0, 16'h0, 1, 0);
      cyc("cnt_d2", 0, 16'h0, 16'h0, 1, 0);
      #1;
`ifdef CTRL_ISSUE_COUNT_EN
      chk("cnt.five", count, 32'd5);
`else
      chk("cnt.zero", count, 32'd0);
`endif

      // Randomized phase
      halt_wait = 0;
      for (int n = 0; n < 600; n++) begin
         op = 5'($urandom_range(0, 31));
         if (op == 5'b00000 && $urandom_range(0, 3) != 0) op = 5'b01000;
         ri = {op, 11'($urandom)};
         cyc("rnd", $urandom_range(0, 3) != 0, ri, 16'($urandom),
             $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
         if (m_halted) halt_wait++;
         if (halt_wait > 3 || $urandom_range(0, 199) == 0) begin
            async_reset();
            halt_wait = 0;
         end
      end
      cyc("final", 0, 16'h0, 16'h0, 1, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Global time bound so the run always ends
   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
